// File: rtl/hera_seq_ctrl.sv
// HERA multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, wait timeout, single-step debug and cycle/instruction counters.
module hera_seq_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [2:0]       op_class,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             rf_we,
    output logic             flags_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_SET    = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_STORE  = 3'd3;
    localparam logic [2:0] OP_BRANCH = 3'd4;
    localparam logic [2:0] OP_FLAGOP = 3'd5;
    localparam logic [2:0] OP_NOP    = 3'd6;
    localparam logic [2:0] OP_HALT   = 3'd7;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t          state_reg, state_next;
    logic            step_mode_reg;
    logic [2:0]      cls_reg;
    logic [15:0]     wait_reg;
    logic [CNT_W-1:0] cycle_reg, instr_reg;
    logic            retire, taken;
    state_t          after_retire;

    assign after_retire = (run && !step_mode_reg) ? S_FETCH : S_IDLE;

    // Enables respond in the same cycle as the ready/decoder inputs so that
    // zero-wait accesses and branches cost no extra cycle.
    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        rf_we      = 1'b0;
        flags_we   = 1'b0;
        retire     = 1'b0;
        taken      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run || step)
                    state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_reg == WAIT_LAST) begin
                    state_next = S_ERR;
                end
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                case (op_class)
                    OP_ALU: begin
                        flags_we   = 1'b1;
                        state_next = S_WB;
                    end
                    OP_SET:   state_next = S_WB;
                    OP_LOAD:  state_next = S_MEM;
                    OP_STORE: state_next = S_MEM;
                    OP_BRANCH: begin
                        retire = 1'b1;
                        taken  = br_taken;
                    end
                    OP_FLAGOP: begin
                        flags_we = 1'b1;
                        retire   = 1'b1;
                    end
                    OP_NOP:   retire = 1'b1;
                    OP_HALT:  state_next = S_HALT;
                endcase
                if (retire)
                    state_next = after_retire;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_reg == OP_STORE);
                if (dmem_ready) begin
                    if (cls_reg == OP_STORE) begin
                        retire     = 1'b1;
                        state_next = after_retire;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (wait_reg == WAIT_LAST) begin
                    state_next = S_ERR;
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                retire     = 1'b1;
                state_next = after_retire;
            end
            S_HALT: state_next = S_HALT;
            S_ERR:  state_next = S_ERR;
        endcase
    end

    assign pc_inc  = retire && !taken;
    assign pc_load = retire && taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            step_mode_reg <= 1'b0;
            cls_reg       <= OP_ALU;
            wait_reg      <= '0;
            cycle_reg     <= '0;
            instr_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && (run || step))
                step_mode_reg <= !run;
            if (state_reg == S_EXEC)
                cls_reg <= op_class;
            // Any state change is an entry into a new wait window.
            if (state_next != state_reg)
                wait_reg <= '0;
            else if ((state_reg == S_FETCH && !imem_ready) ||
                     (state_reg == S_MEM && !dmem_ready))
                wait_reg <= wait_reg + 16'd1;
            if (state_reg inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB})
                cycle_reg <= cycle_reg + 1'b1;
            if (retire)
                instr_reg <= instr_reg + 1'b1;
        end
    end

    assign state     = state_reg;
    assign halted    = (state_reg == S_HALT);
    assign error     = (state_reg == S_ERR);
    assign cycle_cnt = cycle_reg;
    assign instr_cnt = instr_reg;

endmodule

// File: doc/hera_seq_ctrl.md
Name: hera_seq_ctrl

Overview:
- Multi-cycle control sequencer for the HERA core: FETCH / DECODE / EXEC / MEM / WB.
- Drives PC, IR, register-file and flag-register write enables.
- Handshakes with instruction and data memory; supports free-run and single-step debug.
- Sits between the decoder (supplies op class and branch decision) and the datapath enables.

Parameters:
CNT_W, 32, width of cycle_cnt and instr_cnt
TIMEOUT, 255, max wait cycles for imem_ready/dmem_ready before entering ERR (1..2^16-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  level; 1 = execute continuously
step  in  1  one-cycle pulse; execute exactly one instruction when idle
op_class  in  3  decoder class of IR: 0 ALU, 1 SET, 2 LOAD, 3 STORE, 4 BRANCH, 5 FLAGOP, 6 NOP, 7 HALT
br_taken  in  1  decoder branch-condition result, valid in EXEC
imem_ready  in  1  instruction word valid
dmem_ready  in  1  data access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
dmem_we  out  1  data write (STORE)
ir_we  out  1  load IR
pc_inc  out  1  PC <= PC+1
pc_load  out  1  PC <= branch target
rf_we  out  1  register-file write
flags_we  out  1  flag-register (S,Z,V,C) write
state  out  3  0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 WB, 6 HALT, 7 ERR
halted  out  1  state==HALT
error  out  1  state==ERR
cycle_cnt  out  CNT_W  active cycles
instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (async, any state):
  - state=IDLE; all outputs 0; counters 0; wait counter 0; step_mode 0.
- IDLE:
  - run=1 -> FETCH with step_mode=0.
  - else step=1 -> FETCH with step_mode=1.
  - run dominates step; step while not IDLE is ignored.
- FETCH:
  - imem_req=1 held every cycle until imem_ready.
  - imem_ready=1: ir_we=1 that cycle -> DECODE. Zero-wait fetch takes 1 cycle.
- DECODE: one cycle, no enables -> EXEC.
- EXEC: op_class sampled and latched into cls_q.
  - ALU: flags_we=1 -> WB.
  - SET: -> WB.
  - LOAD/STORE: -> MEM.
  - FLAGOP: flags_we=1, retire.
  - NOP: retire.
  - BRANCH: retire; pc_load=br_taken; no pc_inc if taken.
  - HALT: -> HALT; no pc_inc; instr_cnt unchanged.
- MEM:
  - dmem_req=1 held until dmem_ready; dmem_we=1 iff cls_q==STORE.
  - On dmem_ready: STORE retires; LOAD -> WB.
- WB: rf_we=1, retire.
- Retire cycle (last cycle of an instruction):
  - pc_inc=1, except taken branch (pc_load=1 instead); instr_cnt+1.
  - Next state: FETCH if run=1 and step_mode=0, else IDLE.
  - run dropping mid-instruction: the instruction completes, then IDLE.
- Latency, zero-wait memories: ALU/SET 4 cycles, LOAD 5, STORE 4, BRANCH/FLAGOP/NOP 3.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle ready=0.
  - Reaching TIMEOUT with ready=0 -> ERR; request drops.
- HALT and ERR: sticky until rst; all enables 0; run/step ignored.
- cycle_cnt: +1 every cycle in FETCH..WB; wraps modulo 2^CNT_W. instr_cnt also wraps.
- Exactly one of pc_inc/pc_load per retired instruction.
- ir_we, rf_we, flags_we are single-cycle pulses, never asserted in IDLE/HALT/ERR.

Test Plan:
- Reset then run=1, both readys tied 1, op_class=ALU constant -> states 1,2,3,5 repeating; flags_we at EXEC, rf_we+pc_inc at WB; instr_cnt=3 after 12 cycles; cycle_cnt=12.
- step pulse, run=0, op_class=LOAD, dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, rf_we once, instr_cnt=1, back to IDLE after 8 cycles; a second step repeats.
- run=1, BRANCH with br_taken=1, then BRANCH with br_taken=0 -> first pc_load=1/pc_inc=0, second pc_inc=1/pc_load=0, each 3 cycles.
- imem_ready held 0, TIMEOUT=4 -> imem_req high 4 cycles, then state=7, error=1; run toggling has no effect until rst.
- run=1, op_class=HALT -> state=6, halted=1, instr_cnt unchanged, no pc_inc; rst asserted -> IDLE, counters 0.
- rst asserted mid-MEM of a STORE (dmem_ready=0) -> outputs 0 immediately (asynchronous); after release, state=IDLE and dmem_we=0.
